// File: rtl/rr_arb4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb4
// Brief    : 4:1 round-robin arbiter into a one-deep registered output stage.
//            Optional 16-bit saturating transfer counter: RR_ARB4_XFER_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb4 #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [3:0]       i_valid,
    input  logic [WIDTH-1:0] i_data0,
    input  logic [WIDTH-1:0] i_data1,
    input  logic [WIDTH-1:0] i_data2,
    input  logic [WIDTH-1:0] i_data3,
    output logic [3:0]       o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_sel,
    input  logic             i_ready
`ifdef RR_ARB4_XFER_CNT_EN
    ,
    output logic [15:0]      o_xfer_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_win;
    logic [1:0]       w_idx;
    logic             w_any;
    logic             w_free;
    logic             w_xfer;
    logic [WIDTH-1:0] w_win_data;

    assign o_valid = (r_state == ST_FULL);
    assign w_free  = !o_valid || i_ready;
    assign w_any   = |i_valid;

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        w_win = r_ptr;
        w_idx = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_ptr + 2'(k);
            if (i_valid[w_idx]) begin
                w_win = w_idx;
            end
        end
    end

    always_comb begin
        o_ready = 4'b0000;
        if (i_rst_n && w_free && w_any) begin
            o_ready[w_win] = 1'b1;
        end
    end

    assign w_xfer = |o_ready;

    always_comb begin
        case (w_win)
            2'd0:    w_win_data = i_data0;
            2'd1:    w_win_data = i_data1;
            2'd2:    w_win_data = i_data2;
            default: w_win_data = i_data3;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
            ST_FULL: begin
                if (w_xfer)       w_state_nxt = ST_FULL;
                else if (i_ready) w_state_nxt = ST_EMPTY;
            end
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_data <= '0;
            o_sel  <= 2'd0;
            r_ptr  <= 2'd0;
        end else if (w_xfer) begin
            o_data <= w_win_data;
            o_sel  <= w_win;
            r_ptr  <= w_win + 2'd1;
        end
    end

`ifdef RR_ARB4_XFER_CNT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_xfer_cnt <= 16'd0;
        end else if (o_valid && i_ready && (o_xfer_cnt != 16'hFFFF)) begin
            o_xfer_cnt <= o_xfer_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_arb4.sv
`default_nettype none
// Testbench for rr_arb4: directed literal checks plus randomized traffic
// compared every cycle against a behavioural round-robin model and scoreboard.
module tb_rr_arb4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] valid;
    logic [7:0] d [4];
    logic [3:0] o_ready;
    logic       o_valid;
    logic [7:0] o_data;
    logic [1:0] o_sel;
    logic       ready;
`ifdef RR_ARB4_XFER_CNT_EN
    logic [15:0] o_xfer_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    rr_arb4 #(.WIDTH(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_valid (valid),
        .i_data0 (d[0]),
        .i_data1 (d[1]),
        .i_data2 (d[2]),
        .i_data3 (d[3]),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_sel   (o_sel),
        .i_ready (ready)
`ifdef RR_ARB4_XFER_CNT_EN
        ,
        .o_xfer_cnt (o_xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: holding register contents, priority pointer, FIFO of accepted words.
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    int         m_sel   = 0;
    int         m_ptr   = 0;
    int         m_cnt   = 0;
    bit         started = 1'b0;
    logic [7:0] sb [$];

    function automatic int winner();
        if (!rst_n || !(!m_valid || ready)) return -1;
        for (int k = 0; k < 4; k++) begin
            if (valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int w;
        w = winner();
        return (w < 0) ? 4'b0000 : 4'(1 << w);
    endfunction

    always @(posedge clk) begin
        int w;
        w = winner();
        started = 1'b1;
        if (!rst_n) begin
            m_valid = 1'b0; m_data = 8'h00; m_sel = 0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (m_valid && ready && m_cnt < 65535) m_cnt++;
            if (w >= 0) begin
                m_valid = 1'b1; m_data = d[w]; m_sel = w; m_ptr = (w + 1) % 4;
            end else if (m_valid && ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int w;
        if (started) begin
            w = winner();
            chk("o_ready", 32'(o_ready), 32'(exp_ready()));
            chk("o_valid", 32'(o_valid), 32'(m_valid));
            chk("o_data",  32'(o_data),  32'(m_data));
            chk("o_sel",   32'(o_sel),   32'(m_sel));
`ifdef RR_ARB4_XFER_CNT_EN
            chk("o_xfer_cnt", 32'(o_xfer_cnt), 32'(m_cnt));
`endif
            if (!rst_n) begin
                sb.delete();
            end else begin
                if (o_valid && ready) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'(sb.size()), 32'd1);
                    end else begin
                        chk("sb_word", 32'(o_data), 32'(sb.pop_front()));
                    end
                end
                if (w >= 0) sb.push_back(d[w]);
                chk("sb_depth", 32'(sb.size() > 1), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; valid = 4'b0000; ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data",  32'(o_data),  32'd0);
        chk("rst_sel",   32'(o_sel),   32'd0);
        tick();

        // All four requesting with ready high: strict rotation 0,1,2,3,0
        valid = 4'b1111; ready = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 8'h10 + 8'(i);
        @(negedge clk);
        chk("rot_first_ready", 32'(o_ready), 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rot_sel",  32'(o_sel),  32'(i % 4));
            chk("rot_data", 32'(o_data), 32'(8'h10 + 8'(i % 4)));
        end

        // Single requester 2
        tick(); valid = 4'b0000;
        tick(); valid = 4'b0100; d[2] = 8'hA5;
        @(negedge clk);
        chk("solo_ready", 32'(o_ready), 32'h4);
        tick(); valid = 4'b1111;
        @(negedge clk);
        chk("solo_valid", 32'(o_valid), 32'd1);
        chk("solo_data",  32'(o_data),  32'hA5);
        chk("solo_sel",   32'(o_sel),   32'd2);
        chk("ptr3_ready", 32'(o_ready), 32'h8);

        // Backpressure hold
        tick(); ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_ready", 32'(o_ready), 32'h0);
            chk("hold_sel",   32'(o_sel),   32'd3);
            chk("hold_data",  32'(o_data),  32'h13);
        end
        tick(); ready = 1'b1;
        @(negedge clk);
        chk("release_ready", 32'(o_ready), 32'h1);
        @(negedge clk);
        chk("release_sel", 32'(o_sel), 32'd0);

        // Pointer wrap: ptr=3 with requesters 0,1
        tick(); valid = 4'b0000;
        tick(); d[1] = 8'h5A; valid = 4'b0100;
        tick(); valid = 4'b0011;
        @(negedge clk);
        chk("wrap_ready0", 32'(o_ready), 32'h1);
        tick();
        @(negedge clk);
        chk("wrap_ready1", 32'(o_ready), 32'h2);
        tick(); valid = 4'b0000; ready = 1'b0;
        @(negedge clk);
        chk("full_5a", 32'(o_data), 32'h5A);

        // Reset while full
        tick(); rst_n = 1'b0; valid = 4'b1111; ready = 1'b1;
        @(negedge clk);
        chk("rstcyc_ready", 32'(o_ready), 32'h0);
        tick();
        @(negedge clk);
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_data",  32'(o_data),  32'd0);
        chk("midrst_sel",   32'(o_sel),   32'd0);
        tick(); rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_ready", 32'(o_ready), 32'h1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst_n = ($urandom_range(0, 199) != 0);
            valid = 4'($urandom);
            if ($urandom_range(0, 3) == 0) valid = 4'($urandom) & 4'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        end

`ifdef RR_ARB4_XFER_CNT_EN
        tick(); rst_n = 1'b1; valid = 4'b1111; ready = 1'b1;
        repeat (70000) tick();
        @(negedge clk);
        chk("cnt_sat", 32'(o_xfer_cnt), 32'hFFFF);
`endif

        tick(); valid = 4'b0000;
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
